// File: rtl/tmds_serializer_diff.sv
// Purpose : TMDS output stage. Buffers 10-bit word groups, serialises each lane LSB-first,
//           generates the TMDS clock lane and drives p/n pin pairs (DDR or SDR).
// Latency : a group popped at the load cycle has bit0 in the pin register one cycle later;
//           in DDR builds it reaches the pin one output-register stage after that.
// Backpr. : in_ready is the registered "FIFO not full"; words are taken on in_valid && in_ready.
//
// Ports
//   clk_shift  bit/shift clock (5x pixel clock for DDR, 10x for SDR)
//   reset      asynchronous, active-high
//   enable     1: drain FIFO at each load; 0: send IDLE_WORD and hold the FIFO
//   in_valid   word group offered
//   in_ready   FIFO can accept a group
//   in_data    lane k at [k*WORD_W +: WORD_W]
//   word_start one-cycle pulse after every shifter load
//   underflow  sticky: a load found the FIFO empty while enabled
//   out_p/out_n pin pairs, index DATA_LANES is the clock lane

// Purpose : generic word FIFO, power-of-two depth.
// Latency : a written word is readable the cycle after the write.
// Backpr. : wr_rdy is registered from the next-cycle occupancy; low when full and in reset.
module tmds_word_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  output logic             wr_rdy,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_dat,
  output logic             empty
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CNW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNW-1:0]   count;
  logic [CNW-1:0]   count_next;
  logic             push;
  logic             pop;

  assign push       = wr_vld && wr_rdy;
  assign pop        = rd_en && !empty;
  assign empty      = (count == '0);
  // A write while full is impossible because wr_rdy is low then, so the
  // occupancy can never overflow; push+pop together leaves it unchanged.
  assign count_next = count + CNW'(push) - CNW'(pop);
  assign rd_dat     = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wr_rdy <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count  <= count_next;
      wr_rdy <= (count_next != CNW'(DEPTH));
    end
  end

  // Storage needs no reset: the pointers define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end
endmodule

// Purpose : behavioural equivalent of the ECP5 ODDRX1F (d0 in the high phase, d1 in the low phase).
// Latency : one clk rising edge from d0/d1 to q.
// Backpr. : none; free-running output stage, async reset forces q to RST_VAL.
module tmds_oddr #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d0,
  input  logic d1,
  output logic q
);
  logic r0;
  logic r1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0 <= RST_VAL;
      r1 <= RST_VAL;
    end else begin
      r0 <= d0;
      r1 <= d1;
    end
  end

  // First half of the bit period carries d0, second half d1.
  assign q = clk ? r0 : r1;
endmodule

// Purpose : TMDS serialiser top, see file header.
// Latency : load cycle -> pin register next cycle (+1 ODDR stage when DDR=1).
// Backpr. : in_ready low when the word FIFO is full.
module tmds_serializer_diff #(
  parameter int                  DATA_LANES  = 3,
  parameter int                  WORD_W      = 10,
  parameter int                  DDR         = 1,
  parameter int                  FIFO_DEPTH  = 4,
  parameter logic [WORD_W-1:0]   IDLE_WORD   = 10'b1101010100,
  parameter logic [WORD_W-1:0]   CLK_WORD    = 10'b0000011111,
  parameter logic [DATA_LANES:0] INVERT_MASK = '0
) (
  input  logic                         clk_shift,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_LANES*WORD_W-1:0] in_data,
  output logic                         word_start,
  output logic                         underflow,
  output logic [DATA_LANES:0]          out_p,
  output logic [DATA_LANES:0]          out_n
);
  // WORD_W must be even for DDR builds and FIFO_DEPTH a power of two >= 2.
  localparam int STEP   = (DDR != 0) ? 2 : 1;
  localparam int PERIOD = WORD_W / STEP;
  localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int GW     = DATA_LANES * WORD_W;

  logic [CW-1:0]                   cnt;
  logic                            load;
  logic                            fifo_empty;
  logic [GW-1:0]                   fifo_dat;
  logic                            pop;
  logic [DATA_LANES:0][WORD_W-1:0] sh_q;
  logic [DATA_LANES:0][WORD_W-1:0] sh_d;
  logic [DATA_LANES:0][STEP-1:0]   bits_d;
  logic [DATA_LANES:0][STEP-1:0]   pin_p_q;
  logic [DATA_LANES:0][STEP-1:0]   pin_n_q;

  // The last cycle of every word period is the load cycle; the enable value
  // sampled here decides what the next word is, so mid-word enable changes
  // only take effect at the following word boundary.
  assign load = (cnt == CW'(PERIOD - 1));
  assign pop  = load && enable && !fifo_empty;

  tmds_word_fifo #(
    .WIDTH (GW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk_shift),
    .rst    (reset),
    .wr_vld (in_valid),
    .wr_rdy (in_ready),
    .wr_dat (in_data),
    .rd_en  (pop),
    .rd_dat (fifo_dat),
    .empty  (fifo_empty)
  );

  // Word period counter.
  always_ff @(posedge clk_shift or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Next shifter contents. The pin register samples the low bits of the
  // next value, so a freshly loaded word has bit0 in the pin register in
  // the cycle right after the load, and all lanes switch word together
  // with the clock lane's rising pattern.
  always_comb begin
    sh_d   = sh_q;
    bits_d = '0;
    for (int k = 0; k < DATA_LANES; k++) begin
      if (load) begin
        sh_d[k] = pop ? fifo_dat[k*WORD_W +: WORD_W] : IDLE_WORD;
      end else begin
        sh_d[k] = sh_q[k] >> STEP;
      end
    end
    sh_d[DATA_LANES] = load ? CLK_WORD : (sh_q[DATA_LANES] >> STEP);
    for (int k = 0; k <= DATA_LANES; k++) begin
      bits_d[k] = sh_d[k][STEP-1:0];
    end
  end

  always_ff @(posedge clk_shift or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DATA_LANES; k++) begin
        sh_q[k] <= IDLE_WORD;
      end
      sh_q[DATA_LANES] <= CLK_WORD;
    end else begin
      sh_q <= sh_d;
    end
  end

  // Status: word_start marks the cycle whose pin register holds bit0.
  always_ff @(posedge clk_shift or posedge reset) begin
    if (reset) begin
      word_start <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      word_start <= load;
      if (load && enable && fifo_empty) underflow <= 1'b1;
    end
  end

  // Pin register stage; the per-lane polarity swap is folded in here so the
  // serial data path stays polarity-agnostic.
  always_ff @(posedge clk_shift or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= DATA_LANES; k++) begin
        pin_p_q[k] <= {STEP{INVERT_MASK[k]}};
        pin_n_q[k] <= {STEP{~INVERT_MASK[k]}};
      end
    end else begin
      for (int k = 0; k <= DATA_LANES; k++) begin
        pin_p_q[k] <= bits_d[k] ^ {STEP{INVERT_MASK[k]}};
        pin_n_q[k] <= ~bits_d[k] ^ {STEP{INVERT_MASK[k]}};
      end
    end
  end

  for (genvar k = 0; k <= DATA_LANES; k++) begin : g_pin
    if (DDR != 0) begin : g_ddr
      tmds_oddr #(
        .RST_VAL (INVERT_MASK[k])
      ) u_oddr_p (
        .clk (clk_shift),
        .rst (reset),
        .d0  (pin_p_q[k][0]),
        .d1  (pin_p_q[k][STEP-1]),
        .q   (out_p[k])
      );
      tmds_oddr #(
        .RST_VAL (~INVERT_MASK[k])
      ) u_oddr_n (
        .clk (clk_shift),
        .rst (reset),
        .d0  (pin_n_q[k][0]),
        .d1  (pin_n_q[k][STEP-1]),
        .q   (out_n[k])
      );
    end else begin : g_sdr
      assign out_p[k] = pin_p_q[k][0];
      assign out_n[k] = pin_n_q[k][0];
    end
  end
endmodule

// File: tb/tb_tmds_serializer_diff.sv
// Testbench for tmds_serializer_diff (DDR build, lane 1 polarity swapped).
// A transaction-level model (group queue + word-period arithmetic) predicts
// every word each lane must carry; a monitor rebuilds words from the pins.
module tb_tmds_serializer_diff;
  localparam int          DL    = 3;
  localparam int          W     = 10;
  localparam int          DEPTH = 4;
  localparam int          PER   = 5;
  localparam logic [3:0]  INV   = 4'b0010;
  localparam logic [9:0]  IDLE  = 10'b1101010100;
  localparam logic [9:0]  CLKW  = 10'b0000011111;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          in_valid;
  logic          in_ready;
  logic [29:0]   in_data;
  logic          word_start;
  logic          underflow;
  logic [3:0]    out_p;
  logic [3:0]    out_n;

  tmds_serializer_diff #(
    .DATA_LANES  (DL),
    .WORD_W      (W),
    .DDR         (1),
    .FIFO_DEPTH  (DEPTH),
    .IDLE_WORD   (IDLE),
    .CLK_WORD    (CLKW),
    .INVERT_MASK (INV)
  ) dut (
    .clk_shift  (clk),
    .reset      (rst),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .word_start (word_start),
    .underflow  (underflow),
    .out_p      (out_p),
    .out_n      (out_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_cmp = 0;
  int          n_err = 0;
  logic [29:0] mq[$];   // model of buffered groups
  logic [29:0] sb[$];   // expected group per word period
  bit          uf_m   = 1'b0;
  bit          rdy_m  = 1'b0;
  int          edge_n = 0;
  bit          mon_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge: apply the model's view of that edge, then compare status.
  task automatic cycle();
    logic [29:0] g;
    @(posedge clk);
    edge_n++;
    if (edge_n % PER == 0) begin
      if (enable && mq.size() > 0) begin
        g = mq.pop_front();
      end else begin
        g = {IDLE, IDLE, IDLE};
        if (enable) uf_m = 1'b1;
      end
      sb.push_back(g);
    end
    if (in_valid && rdy_m) mq.push_back(in_data);
    rdy_m = (mq.size() < DEPTH);
    #1;
    check("in_ready", {31'b0, in_ready}, {31'b0, rdy_m});
    check("underflow", {31'b0, underflow}, {31'b0, uf_m});
    check("word_start", {31'b0, word_start}, {31'b0, (edge_n % PER == 0)});
  endtask

  // Monitor: rebuilds words from the pins, high phase = even bit, low = odd.
  logic [9:0] cur [4];
  int         idx        = 0;
  bit         collecting = 1'b0;
  bit         prev_ws    = 1'b0;
  bit         nbad       = 1'b0;

  task automatic mon_sample(input bit hi);
    logic [29:0] exp;
    if (hi) begin
      if (prev_ws) begin
        collecting = 1'b1;
        idx        = 0;
        nbad       = 1'b0;
      end
      prev_ws = word_start;
    end
    if (collecting) begin
      for (int l = 0; l < 4; l++) cur[l][idx] = out_p[l] ^ INV[l];
      if (out_n !== ~out_p) nbad = 1'b1;
      idx++;
      if (idx == W) begin
        collecting = 1'b0;
        if (sb.size() == 0) begin
          check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
          exp = sb.pop_front();
          for (int l = 0; l < DL; l++)
            check($sformatf("lane%0d_word", l), {22'b0, cur[l]}, {22'b0, exp[l*W +: W]});
          check("clock_lane_word", {22'b0, cur[3]}, {22'b0, CLKW});
          check("p_n_complement", {31'b0, nbad}, 32'd0);
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (mon_en && !rst) mon_sample(1'b1);
      @(negedge clk); #1;
      if (mon_en && !rst) mon_sample(1'b0);
    end
  end

  task automatic drive_rand_group();
    logic [31:0] r;
    r       = $urandom();
    in_data = r[29:0];
  endtask

  logic [9:0] dir_words [3];

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_underflow", {31'b0, underflow}, 32'd0);
    check("rst_word_start", {31'b0, word_start}, 32'd0);
    check("rst_out_p", {28'b0, out_p}, {28'b0, INV});
    check("rst_out_n", {28'b0, out_n}, {28'b0, ~INV});
    rst = 1'b0;

    // Idle with enable low: idle symbols and clock pattern only.
    repeat (30) cycle();

    // Three directed words on lane 0, then drain and run into underflow.
    dir_words[0] = 10'h3FF;
    dir_words[1] = 10'h000;
    dir_words[2] = 10'h155;
    for (int i = 0; i < 3; i++) begin
      drive_rand_group();
      in_data[9:0] = dir_words[i];
      in_valid     = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    enable   = 1'b1;
    repeat (30) cycle();

    // Fill with no drain: DEPTH+1 back-to-back offers.
    enable = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive_rand_group();
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    repeat (3) cycle();
    enable = 1'b1;
    repeat (30) cycle();

    // Push and pop in the same load cycle with two groups buffered.
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_rand_group();
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    while (edge_n % PER != PER - 1) cycle();
    enable = 1'b1;
    drive_rand_group();
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (30) cycle();

    // Randomised traffic with enable toggling at arbitrary points.
    for (int i = 0; i < 400; i++) begin
      enable   = ($urandom_range(0, 9) != 0);
      in_valid = $urandom_range(0, 1) == 1;
      drive_rand_group();
      cycle();
    end
    in_valid = 1'b0;
    enable   = 1'b1;
    repeat (20) cycle();
    check("scoreboard_drained", {31'b0, (sb.size() <= 2)}, 32'd1);

    // Reset in the middle of a word: pins return to idle polarity at once.
    mon_en = 1'b0;
    while (edge_n % PER != 2) cycle();
    #3;
    rst = 1'b1;
    #1;
    check("midrst_out_p", {28'b0, out_p}, {28'b0, INV});
    check("midrst_out_n", {28'b0, out_n}, {28'b0, ~INV});
    check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    check("midrst_underflow", {31'b0, underflow}, 32'd0);
    check("midrst_word_start", {31'b0, word_start}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
